// File: rtl/fc8_audio_sweep_env.sv
// Per-channel envelope/sweep sequencer feeding audio_channel from CPU audio SFR writes.
// Optional note-length counter enabled by defining FC8_AUDIO_LENGTH_EN.
module fc8_audio_sweep_env #(
  parameter int TICK_DIV = 20833,
  parameter int FREQ_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sfr_we,
  input  logic [2:0]        sfr_sel,
  input  logic [7:0]        sfr_wdata,
  output logic [FREQ_W-1:0] freq_val,
  output logic [3:0]        volume,
  output logic              active,
  output logic              tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] SEL_FREQ_LO = 3'd0;
  localparam logic [2:0] SEL_FREQ_HI = 3'd1;
  localparam logic [2:0] SEL_ENV     = 3'd2;
  localparam logic [2:0] SEL_SWEEP   = 3'd3;
`ifdef FC8_AUDIO_LENGTH_EN
  localparam logic [2:0] SEL_LENGTH  = 3'd4;
`endif

  logic [PW-1:0]     r_pre;
  logic [7:0]        r_lo;
  logic [7:0]        r_env;
  logic [6:0]        r_sweep;
  logic [FREQ_W-1:0] r_freq;
  logic [3:0]        r_vol;
  logic [2:0]        r_env_cnt;
  logic [2:0]        r_sw_cnt;
  logic              r_active;
`ifdef FC8_AUDIO_LENGTH_EN
  logic              r_len_en;
  logic [6:0]        r_len_cnt;
`endif

  logic              w_tick;
  logic              w_trig;
  logic [3:0]        w_env_nxt;
  logic [3:0]        w_sw_nxt;
  logic              w_env_step;
  logic              w_sw_step;
  logic [3:0]        w_vol_nxt;
  logic [FREQ_W-1:0] w_delta;
  logic [FREQ_W:0]   w_sum;

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));
  assign w_trig = sfr_we && (sfr_sel == SEL_FREQ_HI);

  always_comb begin
    w_env_nxt  = {1'b0, r_env_cnt} + 4'd1;
    w_sw_nxt   = {1'b0, r_sw_cnt} + 4'd1;
    w_env_step = (w_env_nxt >= {1'b0, r_env[2:0]});
    w_sw_step  = (w_sw_nxt >= {1'b0, r_sweep[6:4]});
    w_vol_nxt  = r_vol;
    if (r_env[3]) begin
      if (r_vol != 4'hF) w_vol_nxt = r_vol + 4'd1;
    end else if (r_vol != 4'h0) begin
      w_vol_nxt = r_vol - 4'd1;
    end
    // delta never exceeds r_freq, so the negate path cannot underflow
    w_delta = r_freq >> r_sweep[2:0];
    w_sum   = {1'b0, r_freq} + {1'b0, w_delta};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_lo      <= '0;
      r_env     <= '0;
      r_sweep   <= '0;
      r_freq    <= '0;
      r_vol     <= '0;
      r_env_cnt <= '0;
      r_sw_cnt  <= '0;
      r_active  <= 1'b0;
`ifdef FC8_AUDIO_LENGTH_EN
      r_len_en  <= 1'b0;
      r_len_cnt <= '0;
`endif
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);

      // a trigger landing on a tick discards that tick's steps
      if (w_trig) begin
        r_freq    <= FREQ_W'({sfr_wdata, r_lo});
        r_vol     <= r_env[7:4];
        r_env_cnt <= '0;
        r_sw_cnt  <= '0;
        r_active  <= 1'b1;
`ifdef FC8_AUDIO_LENGTH_EN
        if (r_len_cnt == 7'd0) r_len_cnt <= 7'd64;
`endif
      end else if (w_tick && r_active) begin
        if (r_env[2:0] != 3'd0) begin
          if (w_env_step) begin
            r_env_cnt <= '0;
            r_vol     <= w_vol_nxt;
          end else begin
            r_env_cnt <= w_env_nxt[2:0];
          end
        end
        if (r_sweep[6:4] != 3'd0) begin
          if (w_sw_step) begin
            r_sw_cnt <= '0;
            if (r_sweep[3])        r_freq   <= r_freq - w_delta;
            else if (w_sum[FREQ_W]) r_active <= 1'b0;
            else                    r_freq   <= w_sum[FREQ_W-1:0];
          end else begin
            r_sw_cnt <= w_sw_nxt[2:0];
          end
        end
`ifdef FC8_AUDIO_LENGTH_EN
        if (r_len_en && (r_len_cnt != 7'd0)) begin
          r_len_cnt <= r_len_cnt - 7'd1;
          if (r_len_cnt == 7'd1) r_active <= 1'b0;
        end
`endif
      end

      if (sfr_we) begin
        case (sfr_sel)
          SEL_FREQ_LO: r_lo    <= sfr_wdata;
          SEL_ENV:     r_env   <= sfr_wdata;
          SEL_SWEEP:   r_sweep <= sfr_wdata[6:0];
`ifdef FC8_AUDIO_LENGTH_EN
          SEL_LENGTH: begin
            r_len_en  <= sfr_wdata[7];
            r_len_cnt <= {1'b0, sfr_wdata[5:0]};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign freq_val = r_freq;
  assign volume   = r_active ? r_vol : 4'd0;
  assign active   = r_active;
  assign tick     = w_tick;

endmodule
